mmsa_input_loader: RTL and testbench
====================================

Name: mmsa_input_loader

Overview:
- Receiving front-end of the MMSA matrix-stream interface.
- Accepts the serial element stream (in_valid, matrix, matrix_size) and writes 16 input matrices and then 16 weight matrices into two SRAM banks.
- Then captures the in_valid2 index pairs (i_mat_idx, w_mat_idx) and issues one compute command per round to the systolic-array controller over a valid/ready handshake.

Parameters:
- DATA_W, 16, element width.
- NUM_MAT, 16, matrices per bank (input and weight).
- ROUNDS, 16, in_valid2 rounds per load.
- ADDR_W, 12, SRAM word address width (NUM_MAT × 16×16 max = 4096).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  element-stream qualifier
- in_valid2  in  1  index-pair qualifier, one cycle per round
- matrix  in  DATA_W  element, row-major
- matrix_size  in  2  size code, sampled on first in_valid cycle: 0=2×2, 1=4×4, 2=8×8, 3=16×16
- i_mat_idx  in  4  input-matrix index
- w_mat_idx  in  4  weight-matrix index
- sram_we  out  1  write strobe
- sram_sel  out  1  0=input bank, 1=weight bank
- sram_addr  out  ADDR_W  word address
- sram_wdata  out  DATA_W  write data
- size_code  out  2  latched matrix_size
- load_done  out  1  one-cycle pulse after the last weight element is written
- cmd_valid  out  1  command available
- cmd_ready  in  1  consumer accepts the command
- cmd_i_idx  out  4  captured input index
- cmd_w_idx  out  4  captured weight index
- cmd_last  out  1  high with the ROUNDS-th command
- err_proto  out  1  sticky protocol-error flag

Behaviour:
- Reset (async, rst_n=0):
  - All outputs 0; size_code=0.
  - All counters 0; state IDLE.
  - Takes effect mid-load or mid-command; any pending command is discarded.
- States: IDLE, LOAD, IDX, DONE_WAIT.
- IDLE:
  - First in_valid=1 cycle latches size_code and writes element 0 (sel=0, addr 0). Go to LOAD.
  - in_valid2 in IDLE sets err_proto; index pair is ignored.
- LOAD:
  - Let S=2^(size_code+1) and E=S*S.
  - elem_cnt counts 0..E-1. mat_cnt counts 0..NUM_MAT-1. bank bit counts 0..1.
  - Each in_valid cycle: sram_addr = (mat_cnt << 2*(size_code+1)) | elem_cnt; sram_sel = bank; then advance counters.
  - Gaps (in_valid=0) pause the counters with no write.
  - After bank=1, mat_cnt=NUM_MAT-1, elem_cnt=E-1 is written: load_done pulses the next cycle; go to IDX.
  - in_valid2 during LOAD sets err_proto and is ignored.
- SRAM write latency: sram_we/sel/addr/wdata are registered, 1 cycle after the sampled in_valid edge. sram_we is 0 on every other cycle.
- IDX:
  - in_valid2=1 with cmd_valid=0: capture cmd_i_idx/cmd_w_idx; cmd_valid=1 next cycle. cmd_last=1 if round_cnt==ROUNDS-1.
  - cmd_valid stays high, with stable fields, until cmd_ready=1. The command is consumed in that cycle; round_cnt increments.
  - in_valid2 while cmd_valid=1 and cmd_ready=0 sets err_proto and drops the new pair. If cmd_ready=1 in the same cycle, the new pair is captured and cmd_valid stays high (back-to-back).
  - in_valid during IDX sets err_proto and is ignored; no SRAM write.
- After the cmd_last handshake: go to DONE_WAIT for 1 cycle, then IDLE.
- The next in_valid starts a fresh load, and matrix_size is re-sampled.
- err_proto clears only on reset.
- Arithmetic: addresses are unsigned and never wrap; the maximum is 16*256-1=4095.

Decomposition:
- Shared package mmsa_pkg: DATA_W, ADDR_W, NUM_MAT, ROUNDS, size-code enum (SZ2, SZ4, SZ8, SZ16), state enum.
- Optional sub-module mmsa_load_addr_gen: elem/mat/bank counters plus shift-OR address, with a single advance input and a last output.
- The FSM and command register stay in the top.

Test Plan:
- 2×2 load: matrix_size=0, 128 consecutive elements valued 0..127 -> 128 writes. Element 64 goes to sel=1, addr 0. Last write is sel=1, addr 63, wdata 127. load_done pulses 1 cycle after that write.
- 16×16 load: 8192 elements -> last write sel=1, addr 4095. Inserting a 5-cycle in_valid gap at element 300 shifts no addresses.
- Command handshake: after the load, 16 in_valid2 pulses (i=k, w=15-k) with cmd_ready tied to 1 -> 16 commands with matching indices. cmd_last=1 only on k=15. FSM returns to IDLE.
- Backpressure: cmd_ready=0 for 10 cycles; second in_valid2 arrives in that window -> err_proto=1, first command held stable, second dropped.
- Protocol errors: in_valid2 during LOAD, and in_valid during IDX -> err_proto=1, no SRAM write, load and command counts unaffected.
- Reset mid-load: rst_n=0 at element 50 -> all outputs 0 immediately. Fresh 4×4 load afterwards starts at addr 0, sel 0.

Source files
------------

// File: rtl/mmsa_pkg.sv
// Shared parameters, enums and helpers for the MMSA input loader.
// Imported by the interface, the address generator and the top.
package mmsa_pkg;

   localparam int DATA_W  = 16;
   localparam int ADDR_W  = 12;
   localparam int NUM_MAT = 16;
   localparam int ROUNDS  = 16;
   localparam int ELEM_W  = 8;
   localparam int MAT_W   = 4;
   localparam int IDX_W   = 4;
   localparam int RND_W   = 4;

   typedef enum logic [1:0] {
      SZ2  = 2'd0,
      SZ4  = 2'd1,
      SZ8  = 2'd2,
      SZ16 = 2'd3
   } size_e;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LOAD      = 2'd1,
      IDX       = 2'd2,
      DONE_WAIT = 2'd3
   } state_e;

   // Index of the final element of one S x S matrix (E-1).
   function automatic logic [ELEM_W-1:0] last_elem(input size_e sz);
      case (sz)
         SZ2:     return 8'd3;
         SZ4:     return 8'd15;
         SZ8:     return 8'd63;
         default: return 8'd255;
      endcase
   endfunction

endpackage

// File: rtl/mmsa_input_loader_if.sv
// Stream, SRAM-write and command signals of the MMSA input loader.
// The loader uses the slave modport; the stream source/consumer side uses master.
interface mmsa_input_loader_if;
   import mmsa_pkg::*;

   logic              in_valid;
   logic              in_valid2;
   logic [DATA_W-1:0] matrix;
   logic [1:0]        matrix_size;
   logic [IDX_W-1:0]  i_mat_idx;
   logic [IDX_W-1:0]  w_mat_idx;
   logic              sram_we;
   logic              sram_sel;
   logic [ADDR_W-1:0] sram_addr;
   logic [DATA_W-1:0] sram_wdata;
   logic [1:0]        size_code;
   logic              load_done;
   logic              cmd_valid;
   logic              cmd_ready;
   logic [IDX_W-1:0]  cmd_i_idx;
   logic [IDX_W-1:0]  cmd_w_idx;
   logic              cmd_last;
   logic              err_proto;

   modport master (
      output in_valid, in_valid2, matrix, matrix_size, i_mat_idx, w_mat_idx, cmd_ready,
      input  sram_we, sram_sel, sram_addr, sram_wdata, size_code, load_done,
             cmd_valid, cmd_i_idx, cmd_w_idx, cmd_last, err_proto
   );

   modport slave (
      input  in_valid, in_valid2, matrix, matrix_size, i_mat_idx, w_mat_idx, cmd_ready,
      output sram_we, sram_sel, sram_addr, sram_wdata, size_code, load_done,
             cmd_valid, cmd_i_idx, cmd_w_idx, cmd_last, err_proto
   );

endinterface

// File: rtl/mmsa_load_addr_gen.sv
// Element/matrix/bank counters for the load phase; forms the SRAM word address.
// All counters wrap back to zero after the final weight element.
module mmsa_load_addr_gen
   import mmsa_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              advance_i,
   input  size_e             size_i,
   output logic [ADDR_W-1:0] addr_o,
   output logic              bank_o,
   output logic              last_o
);

   logic [ELEM_W-1:0] elem_q;
   logic [MAT_W-1:0]  mat_q;
   logic              bank_q;
   logic              elem_end;
   logic              mat_end;
   logic [3:0]        shamt;

   assign elem_end = (elem_q == last_elem(size_i));
   assign mat_end  = (mat_q == MAT_W'(NUM_MAT - 1));
   assign last_o   = bank_q && mat_end && elem_end;
   assign bank_o   = bank_q;

   // Matrix number lands directly above the log2(E) element bits.
   assign shamt  = {1'b0, size_i, 1'b0} + 4'd2;
   assign addr_o = (ADDR_W'(mat_q) << shamt) | ADDR_W'(elem_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         elem_q <= '0;
         mat_q  <= '0;
         bank_q <= 1'b0;
      end else if (advance_i) begin
         if (elem_end) begin
            elem_q <= '0;
            if (mat_end) begin
               mat_q  <= '0;
               bank_q <= ~bank_q;
            end else begin
               mat_q <= mat_q + 1'b1;
            end
         end else begin
            elem_q <= elem_q + 1'b1;
         end
      end
   end

endmodule

// File: rtl/mmsa_input_loader.sv
// MMSA receive front-end: streams input/weight matrices into SRAM, then
// turns in_valid2 index pairs into valid/ready compute commands.
module mmsa_input_loader
   import mmsa_pkg::*;
(
   input logic                clk,
   input logic                rst_n,
   mmsa_input_loader_if.slave ldr_if
);

   state_e            state_q;
   size_e             size_q;
   logic              we_q;
   logic              sel_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              last_wr_q;
   logic              load_done_q;
   logic              cmd_valid_q;
   logic [IDX_W-1:0]  cmd_i_q;
   logic [IDX_W-1:0]  cmd_w_q;
   logic              cmd_last_q;
   logic              err_q;
   logic [RND_W-1:0]  round_q;
   logic [RND_W-1:0]  round_d;

   size_e             gen_size;
   logic [ADDR_W-1:0] gen_addr;
   logic              gen_bank;
   logic              gen_last;
   logic              write_fire;
   logic              handshake;
   logic              capture;
   logic              err_set;

   // In IDLE the size is not latched yet, so the live input steers the generator.
   assign gen_size   = (state_q == IDLE) ? size_e'(ldr_if.matrix_size) : size_q;
   assign write_fire = ldr_if.in_valid && (state_q == IDLE || state_q == LOAD);
   assign handshake  = cmd_valid_q && ldr_if.cmd_ready;
   assign round_d    = round_q + RND_W'(handshake);
   // A pair can enter only when the slot is free or is being emptied, and never past the last round.
   assign capture    = ldr_if.in_valid2 && (state_q == IDX) && !(handshake && cmd_last_q)
                       && (!cmd_valid_q || ldr_if.cmd_ready);
   assign err_set    = (ldr_if.in_valid2 && (state_q == IDLE || state_q == LOAD))
                       || (ldr_if.in_valid && state_q == IDX)
                       || (ldr_if.in_valid2 && state_q == IDX && !capture);

   mmsa_load_addr_gen u_addr_gen (
      .clk       (clk),
      .rst_n     (rst_n),
      .advance_i (write_fire),
      .size_i    (gen_size),
      .addr_o    (gen_addr),
      .bank_o    (gen_bank),
      .last_o    (gen_last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         size_q      <= SZ2;
         we_q        <= 1'b0;
         sel_q       <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         last_wr_q   <= 1'b0;
         load_done_q <= 1'b0;
         cmd_valid_q <= 1'b0;
         cmd_i_q     <= '0;
         cmd_w_q     <= '0;
         cmd_last_q  <= 1'b0;
         err_q       <= 1'b0;
         round_q     <= '0;
      end else begin
         we_q        <= write_fire;
         last_wr_q   <= write_fire && gen_last;
         load_done_q <= last_wr_q;
         if (write_fire) begin
            sel_q   <= gen_bank;
            addr_q  <= gen_addr;
            wdata_q <= ldr_if.matrix;
         end
         if (err_set) begin
            err_q <= 1'b1;
         end

         case (state_q)
            IDLE: begin
               if (ldr_if.in_valid) begin
                  size_q  <= size_e'(ldr_if.matrix_size);
                  state_q <= LOAD;
               end
            end
            LOAD: begin
               if (write_fire && gen_last) begin
                  state_q <= IDX;
               end
            end
            IDX: begin
               if (capture) begin
                  cmd_valid_q <= 1'b1;
                  cmd_i_q     <= ldr_if.i_mat_idx;
                  cmd_w_q     <= ldr_if.w_mat_idx;
                  cmd_last_q  <= (round_d == RND_W'(ROUNDS - 1));
               end else if (handshake) begin
                  cmd_valid_q <= 1'b0;
                  cmd_last_q  <= 1'b0;
               end
               if (handshake) begin
                  if (cmd_last_q) begin
                     round_q <= '0;
                     state_q <= DONE_WAIT;
                  end else begin
                     round_q <= round_d;
                  end
               end
            end
            DONE_WAIT: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign ldr_if.sram_we    = we_q;
   assign ldr_if.sram_sel   = sel_q;
   assign ldr_if.sram_addr  = addr_q;
   assign ldr_if.sram_wdata = wdata_q;
   assign ldr_if.size_code  = size_q;
   assign ldr_if.load_done  = load_done_q;
   assign ldr_if.cmd_valid  = cmd_valid_q;
   assign ldr_if.cmd_i_idx  = cmd_i_q;
   assign ldr_if.cmd_w_idx  = cmd_w_q;
   assign ldr_if.cmd_last   = cmd_last_q;
   assign ldr_if.err_proto  = err_q;

endmodule

// File: tb/tb_mmsa_input_loader.sv
// Self-checking bench for mmsa_input_loader: element n of a load is expected
// at bank n/(16E), address n mod 16E; commands are tracked per round.
module tb_mmsa_input_loader;
   import mmsa_pkg::*;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   mmsa_input_loader_if bus ();

   mmsa_input_loader dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .ldr_if (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [43:0] all_outs();
      return {bus.sram_we, bus.sram_sel, bus.sram_addr, bus.sram_wdata, bus.size_code,
              bus.load_done, bus.cmd_valid, bus.cmd_i_idx, bus.cmd_w_idx, bus.cmd_last,
              bus.err_proto};
   endfunction

   task automatic idle_inputs();
      bus.in_valid    = 1'b0;
      bus.in_valid2   = 1'b0;
      bus.matrix      = '0;
      bus.matrix_size = 2'd0;
      bus.i_mat_idx   = '0;
      bus.w_mat_idx   = '0;
   endtask

   task automatic test_reset();
      idle_inputs();
      bus.cmd_ready = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if (all_outs() !== '0) begin
         bad++;
         $display("[TB] FAIL reset_outputs: got %h want 0", all_outs());
      end
      rst_n = 1'b1;
      @(negedge clk);
      total++;
      if (all_outs() !== '0) begin
         bad++;
         $display("[TB] FAIL post_reset_idle: got %h want 0", all_outs());
      end
   endtask

   // Streams one load; optional gap (with optional in_valid2 in its first cycle)
   // and optional early stop after stop_at elements.
   task automatic run_load(input int sz, input bit seq_data, input int gap_at,
                           input int gap_len, input bit gap_v2, input int stop_at);
      int          e_cnt;
      int          bank_words;
      int          n_end;
      int          d;
      logic [15:0] dv;
      logic [29:0] exp_w;
      logic [29:0] got_w;
      e_cnt      = 1 << (2 * (sz + 1));
      bank_words = NUM_MAT * e_cnt;
      n_end      = (stop_at >= 0) ? stop_at : 2 * bank_words;
      for (int n = 0; n < n_end; n++) begin
         if (n == gap_at) begin
            for (int g = 0; g < gap_len; g++) begin
               bus.in_valid    = 1'b0;
               bus.in_valid2   = gap_v2 && (g == 0);
               bus.i_mat_idx   = 4'($urandom_range(0, 15));
               bus.w_mat_idx   = 4'($urandom_range(0, 15));
               bus.matrix_size = 2'($urandom_range(0, 3));
               @(negedge clk);
               bus.in_valid2 = 1'b0;
               total++;
               if (bus.sram_we !== 1'b0) begin
                  bad++;
                  $display("[TB] FAIL gap_no_write: got we=%0b want 0 (gap %0d)", bus.sram_we, g);
               end
            end
         end
         d  = seq_data ? n : int'($urandom);
         dv = d[15:0];
         bus.in_valid    = 1'b1;
         bus.matrix      = dv;
         bus.matrix_size = (n == 0) ? 2'(sz) : 2'($urandom_range(0, 3));
         @(negedge clk);
         exp_w = {1'b1, 1'(n / bank_words), 12'(n % bank_words), dv};
         got_w = {bus.sram_we, bus.sram_sel, bus.sram_addr, bus.sram_wdata};
         total++;
         if (got_w !== exp_w) begin
            bad++;
            $display("[TB] FAIL write_elem%0d: got we/sel/addr/data=%h want %h", n, got_w, exp_w);
         end
      end
      bus.in_valid = 1'b0;
      if (stop_at < 0) begin
         total++;
         if (bus.load_done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL load_done_early: got %0b want 0", bus.load_done);
         end
         @(negedge clk);
         total++;
         if ({bus.load_done, bus.sram_we} !== 2'b10) begin
            bad++;
            $display("[TB] FAIL load_done_pulse: got done/we=%b want 10", {bus.load_done, bus.sram_we});
         end
         @(negedge clk);
         total++;
         if (bus.load_done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL load_done_width: got %0b want 0", bus.load_done);
         end
         total++;
         if (bus.size_code !== 2'(sz)) begin
            bad++;
            $display("[TB] FAIL size_code: got %0d want %0d", bus.size_code, sz);
         end
      end
   endtask

   // Issues rounds first_k..ROUNDS-1 with cmd_ready high; each command is
   // expected the cycle after its pulse and consumed the cycle after that.
   task automatic issue_rounds(input bit spec_pattern, input int first_k);
      logic [3:0] pi;
      logic [3:0] pw;
      logic [9:0] exp_c;
      logic [9:0] got_c;
      bus.cmd_ready = 1'b1;
      for (int k = first_k; k < ROUNDS; k++) begin
         pi = spec_pattern ? 4'(k) : 4'($urandom_range(0, 15));
         pw = spec_pattern ? 4'(15 - k) : 4'($urandom_range(0, 15));
         bus.in_valid2 = 1'b1;
         bus.i_mat_idx = pi;
         bus.w_mat_idx = pw;
         @(negedge clk);
         exp_c = {1'b1, pi, pw, k == ROUNDS - 1};
         got_c = {bus.cmd_valid, bus.cmd_i_idx, bus.cmd_w_idx, bus.cmd_last};
         total++;
         if (got_c !== exp_c) begin
            bad++;
            $display("[TB] FAIL cmd_round%0d: got valid/i/w/last=%h want %h", k, got_c, exp_c);
         end
      end
      bus.in_valid2 = 1'b0;
      @(negedge clk);
      total++;
      if (bus.cmd_valid !== 1'b0) begin
         bad++;
         $display("[TB] FAIL cmd_drained: got valid=%0b want 0", bus.cmd_valid);
      end
      @(negedge clk);
      bus.cmd_ready = 1'b0;
   endtask

   task automatic test_load_2x2();
      run_load(0, 1'b1, -1, 0, 1'b0, -1);
   endtask

   task automatic test_commands();
      issue_rounds(1'b1, 0);
      total++;
      if (bus.err_proto !== 1'b0) begin
         bad++;
         $display("[TB] FAIL cmd_no_err: got err=%0b want 0", bus.err_proto);
      end
   endtask

   task automatic test_load_16x16_gap();
      run_load(3, 1'b0, 300, 5, 1'b0, -1);
   endtask

   task automatic test_backpressure();
      logic [3:0] ai;
      logic [3:0] aw;
      ai = 4'($urandom_range(0, 15));
      aw = 4'($urandom_range(0, 15));
      bus.cmd_ready = 1'b0;
      bus.in_valid2 = 1'b1;
      bus.i_mat_idx = ai;
      bus.w_mat_idx = aw;
      @(negedge clk);
      total++;
      if ({bus.cmd_valid, bus.cmd_i_idx, bus.cmd_w_idx} !== {1'b1, ai, aw}) begin
         bad++;
         $display("[TB] FAIL bp_first_cmd: got %h want %h",
                  {bus.cmd_valid, bus.cmd_i_idx, bus.cmd_w_idx}, {1'b1, ai, aw});
      end
      for (int c = 0; c < 10; c++) begin
         bus.in_valid2 = (c == 3);
         bus.i_mat_idx = ~ai;
         bus.w_mat_idx = ~aw;
         @(negedge clk);
         total++;
         if ({bus.cmd_valid, bus.cmd_i_idx, bus.cmd_w_idx} !== {1'b1, ai, aw}) begin
            bad++;
            $display("[TB] FAIL bp_hold%0d: got %h want %h", c,
                     {bus.cmd_valid, bus.cmd_i_idx, bus.cmd_w_idx}, {1'b1, ai, aw});
         end
      end
      bus.in_valid2 = 1'b0;
      total++;
      if (bus.err_proto !== 1'b1) begin
         bad++;
         $display("[TB] FAIL bp_err: got %0b want 1", bus.err_proto);
      end
      bus.cmd_ready = 1'b1;
      @(negedge clk);
      total++;
      if (bus.cmd_valid !== 1'b0) begin
         bad++;
         $display("[TB] FAIL bp_second_dropped: got valid=%0b want 0", bus.cmd_valid);
      end
      issue_rounds(1'b0, 1);
   endtask

   task automatic test_proto_errors();
      test_reset();
      run_load(0, 1'b0, 20, 2, 1'b1, -1);
      total++;
      if (bus.err_proto !== 1'b1) begin
         bad++;
         $display("[TB] FAIL err_in_load: got %0b want 1", bus.err_proto);
      end
      bus.in_valid = 1'b1;
      bus.matrix   = 16'($urandom);
      @(negedge clk);
      bus.in_valid = 1'b0;
      total++;
      if ({bus.sram_we, bus.cmd_valid} !== 2'b00) begin
         bad++;
         $display("[TB] FAIL idx_in_valid_ignored: got we/valid=%b want 00", {bus.sram_we, bus.cmd_valid});
      end
      issue_rounds(1'b0, 0);
      test_reset();
      bus.in_valid2 = 1'b1;
      @(negedge clk);
      bus.in_valid2 = 1'b0;
      total++;
      if ({bus.err_proto, bus.cmd_valid} !== 2'b10) begin
         bad++;
         $display("[TB] FAIL err_in_idle: got err/valid=%b want 10", {bus.err_proto, bus.cmd_valid});
      end
   endtask

   task automatic test_reset_mid_load();
      test_reset();
      run_load(2, 1'b0, -1, 0, 1'b0, 50);
      bus.in_valid = 1'b1;
      bus.matrix   = 16'($urandom);
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (all_outs() !== '0) begin
         bad++;
         $display("[TB] FAIL mid_load_reset: got %h want 0", all_outs());
      end
      idle_inputs();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_load(1, 1'b0, -1, 0, 1'b0, -1);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_load_2x2();
      test_commands();
      test_load_16x16_gap();
      test_backpressure();
      test_proto_errors();
      test_reset_mid_load();
      $display("[TB] test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
